// File: rtl/policy_scan_pkg.sv
// policy_scan_pkg: shared sizes, scan FSM state encoding and small helpers
// for the policy table scanner.
// Configuration macro: POLICY_SCAN_MASK_EN (adds a per-lookup compare mask).
package policy_scan_pkg;

    localparam int AW    = 4;
    localparam int DEPTH = 16;
    localparam int DW    = 32;

    localparam logic [AW-1:0] IDX_ZERO = AW'(0);
    localparam logic [AW-1:0] IDX_ONE  = AW'(1);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        CHECK = 2'd2,
        DONE  = 2'd3
    } scan_state_t;

    // True when the scan pointer sits on the final table entry.
    function automatic logic is_last_idx(input logic [AW-1:0] idx);
        return (idx == LAST_IDX);
    endfunction

    // Advance the scan pointer by one entry.
    function automatic logic [AW-1:0] next_idx(input logic [AW-1:0] idx);
        return idx + IDX_ONE;
    endfunction

endpackage

// File: rtl/policy_scan_if.sv
// policy_scan_if: lookup request / result handshake bundle.
// master = requester, slave = the scanner.
// Configuration macro: POLICY_SCAN_MASK_EN adds lookup_mask.
interface policy_scan_if;
    import policy_scan_pkg::*;

    logic          lookup_valid;
    logic          lookup_ready;
    logic [DW-1:0] lookup_key;
`ifdef POLICY_SCAN_MASK_EN
    logic [DW-1:0] lookup_mask;
`endif
    logic          result_valid;
    logic          result_ready;
    logic          result_hit;
    logic [AW-1:0] result_index;
    logic [DW-1:0] result_data;

    modport master (
`ifdef POLICY_SCAN_MASK_EN
        output lookup_mask,
`endif
        output lookup_valid,
        output lookup_key,
        output result_ready,
        input  lookup_ready,
        input  result_valid,
        input  result_hit,
        input  result_index,
        input  result_data
    );

    modport slave (
`ifdef POLICY_SCAN_MASK_EN
        input  lookup_mask,
`endif
        input  lookup_valid,
        input  lookup_key,
        input  result_ready,
        output lookup_ready,
        output result_valid,
        output result_hit,
        output result_index,
        output result_data
    );

endinterface

// File: rtl/policy_match.sv
// policy_match: entry comparator. An entry of value zero is an empty slot
// and never matches, whatever the key or mask.
module policy_match
    import policy_scan_pkg::*;
(
    input  logic [DW-1:0] data,
    input  logic [DW-1:0] key,
    input  logic [DW-1:0] mask,
    output logic          match
);

    // Masked equality, suppressed for empty entries.
    always_comb begin
        match = 1'b0;
        if (data == {DW{1'b0}}) begin
            match = 1'b0;
        end else begin
            match = ((data & mask) == (key & mask));
        end
    end

endmodule

// File: rtl/policy_scan.sv
// policy_scan: sequential linear search of a 16x32 policy table.
// One table read is issued per entry (ISSUE), its data checked the next
// cycle (CHECK); a read squashed by a concurrent host write is re-issued.
// Host writes pass straight through to the table write port.
// Configuration macro: POLICY_SCAN_MASK_EN (per-lookup compare mask).
module policy_scan
    import policy_scan_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    policy_scan_if.slave  bus,
    input  logic          host_wen,
    input  logic [AW-1:0] host_waddr,
    input  logic [DW-1:0] host_wdata,
    output logic          ram_wen,
    output logic [AW-1:0] ram_waddr,
    output logic [DW-1:0] ram_wdata,
    output logic          ram_go_read,
    output logic [AW-1:0] ram_raddr,
    input  logic [DW-1:0] ram_rdata,
    input  logic          ram_ready
);

    scan_state_t   state_r;
    scan_state_t   state_nx_s;
    logic [AW-1:0] idx_r;
    logic [AW-1:0] idx_nx_s;
    logic [DW-1:0] key_r;
    logic [DW-1:0] key_nx_s;
    logic          hit_r;
    logic          hit_nx_s;
    logic [AW-1:0] index_r;
    logic [AW-1:0] index_nx_s;
    logic [DW-1:0] data_r;
    logic [DW-1:0] data_nx_s;
    logic [DW-1:0] mask_s;
    logic          match_s;
    logic          accept_s;

    assign accept_s = (state_r == IDLE) && bus.lookup_valid;

`ifdef POLICY_SCAN_MASK_EN
    logic [DW-1:0] mask_r;
    logic [DW-1:0] mask_nx_s;

    // Capture the compare mask together with the key on acceptance.
    always_comb begin
        mask_nx_s = mask_r;
        if (accept_s) begin
            mask_nx_s = bus.lookup_mask;
        end else begin
            mask_nx_s = mask_r;
        end
    end

    // Mask register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mask_r <= {DW{1'b1}};
        end else begin
            mask_r <= mask_nx_s;
        end
    end

    assign mask_s = mask_r;
`else
    assign mask_s = {DW{1'b1}};
`endif

    policy_match u_match (
        .data  (ram_rdata),
        .key   (key_r),
        .mask  (mask_s),
        .match (match_s)
    );

    // Host write path is a pure pass-through, independent of scan state.
    always_comb begin
        ram_wen   = host_wen;
        ram_waddr = host_waddr;
        ram_wdata = host_wdata;
    end

    // Next-state and next-value logic for the scan FSM and result latches.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        key_nx_s   = key_r;
        hit_nx_s   = hit_r;
        index_nx_s = index_r;
        data_nx_s  = data_r;
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    key_nx_s   = bus.lookup_key;
                    idx_nx_s   = IDX_ZERO;
                    state_nx_s = ISSUE;
                end else begin
                    state_nx_s = IDLE;
                end
            end
            ISSUE: begin
                state_nx_s = CHECK;
            end
            CHECK: begin
                if (!ram_ready) begin
                    // Read lost to a host write: retry the same entry.
                    state_nx_s = ISSUE;
                end else if (match_s) begin
                    hit_nx_s   = 1'b1;
                    index_nx_s = idx_r;
                    data_nx_s  = ram_rdata;
                    state_nx_s = DONE;
                end else if (is_last_idx(idx_r)) begin
                    hit_nx_s   = 1'b0;
                    index_nx_s = IDX_ZERO;
                    data_nx_s  = {DW{1'b0}};
                    state_nx_s = DONE;
                end else begin
                    idx_nx_s   = next_idx(idx_r);
                    state_nx_s = ISSUE;
                end
            end
            DONE: begin
                if (bus.result_ready) begin
                    state_nx_s = IDLE;
                end else begin
                    state_nx_s = DONE;
                end
            end
            default: begin
                state_nx_s = IDLE;
                idx_nx_s   = IDX_ZERO;
            end
        endcase
    end

    // Scan state, pointer, key and result registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= IDLE;
            idx_r   <= IDX_ZERO;
            key_r   <= {DW{1'b0}};
            hit_r   <= 1'b0;
            index_r <= IDX_ZERO;
            data_r  <= {DW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            key_r   <= key_nx_s;
            hit_r   <= hit_nx_s;
            index_r <= index_nx_s;
            data_r  <= data_nx_s;
        end
    end

    // Table read request is a decode of the state register, so reset
    // removes it at once.
    always_comb begin
        ram_go_read = 1'b0;
        ram_raddr   = IDX_ZERO;
        if (state_r == ISSUE) begin
            ram_go_read = 1'b1;
            ram_raddr   = idx_r;
        end else begin
            ram_go_read = 1'b0;
            ram_raddr   = IDX_ZERO;
        end
    end

    // Handshake outputs decoded from state; result fields from latches.
    always_comb begin
        bus.lookup_ready = (state_r == IDLE);
        bus.result_valid = (state_r == DONE);
        bus.result_hit   = hit_r;
        bus.result_index = index_r;
        bus.result_data  = data_r;
    end

endmodule
